// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter
//   Single-port arbiter/sequencer for the Chip-8 4 KB main RAM. Multiplexes
//   the SD loader upload path, the CPU and the sprite blitter onto one
//   synchronous-read RAM port, and owns the full-RAM clear that runs on
//   reset and on every loader start so no stale bytes survive between ROMs.
//
//   Optional feature: define MEM_CLEAR_EN to build the clear sequencer.
//   Without it reset goes straight to arbitration, clear_req is ignored,
//   busy is tied low and no clear counter exists.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   clear_req               one-cycle pulse requesting a full RAM clear
//   busy                    high while clearing (and in reset when clearing is built)
//   {ld,cpu,blt}_req/_we/_addr/_wdata   requester access, held until granted
//   {ld,cpu,blt}_gnt        grant; the access executes on the RAM this cycle
//   cpu_rvalid, blt_rvalid  read data valid on rdata, one cycle after a read grant
//   rdata                   RAM read data passthrough
//   mem_addr/_we/_wdata     RAM port, mem_rdata RAM read data (1-cycle latency)
module chip8_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,

    input  logic              blt_req,
    input  logic              blt_we,
    input  logic [ADDR_W-1:0] blt_addr,
    input  logic [DATA_W-1:0] blt_wdata,
    output logic              blt_gnt,
    output logic              blt_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              in_clear;
    logic [ADDR_W-1:0] clr_addr;

`ifdef MEM_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {ST_CLEAR, ST_ARB} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        case (state)
            ST_CLEAR: begin
                // Last address written this cycle; counter wraps back to 0.
                clr_cnt_nx = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR)
                    state_nx = ST_ARB;
            end
            ST_ARB: begin
                // The grant issued this cycle still completes; clearing
                // starts on the next cycle.
                if (clear_req) begin
                    state_nx   = ST_CLEAR;
                    clr_cnt_nx = '0;
                end
            end
        endcase
    end

    assign in_clear = (state == ST_CLEAR);
    assign clr_addr = clr_cnt;
    assign busy     = reset | in_clear;
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req;
    assign in_clear = 1'b0;
    assign clr_addr = '0;
    assign busy     = 1'b0;
`endif

    // 1 = blitter took the last cpu/blt grant, so the CPU wins the next tie.
    logic              last_blt;
    logic [ADDR_W-1:0] addr_q;
    logic              arb_en;

    assign arb_en = ~reset & ~in_clear;

    always_comb begin
        ld_gnt  = arb_en & ld_req;
        cpu_gnt = arb_en & ~ld_req & cpu_req & (~blt_req | last_blt);
        blt_gnt = arb_en & ~ld_req & blt_req & (~cpu_req | ~last_blt);
    end

    // RAM port mux. With no access the address holds so the RAM sees a
    // stable port between grants.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = '0;
        if (!reset && in_clear) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
        end else if (ld_gnt) begin
            mem_we    = ld_we;      // loader read: granted, nothing happens
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (blt_gnt) begin
            mem_we    = blt_we;
            mem_addr  = blt_addr;
            mem_wdata = blt_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_blt   <= 1'b1;
            addr_q     <= '0;
            cpu_rvalid <= 1'b0;
            blt_rvalid <= 1'b0;
        end else begin
            if (cpu_gnt)
                last_blt <= 1'b0;
            else if (blt_gnt)
                last_blt <= 1'b1;
            addr_q     <= mem_addr;
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            blt_rvalid <= blt_gnt & ~blt_we;
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
module tb_chip8_mem_arbiter;
    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 4096;
`ifdef MEM_CLEAR_EN
    localparam logic RST_BUSY  = 1'b1;
    localparam logic [7:0] RAM_INIT = 8'h5A;
`else
    localparam logic RST_BUSY  = 1'b0;
    localparam logic [7:0] RAM_INIT = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          reset, clear_req, busy;
    logic          ld_req, ld_we, ld_gnt;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          blt_req, blt_we, blt_gnt, blt_rvalid;
    logic [AW-1:0] blt_addr;
    logic [DW-1:0] blt_wdata;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [7:0] ram    [DEPTH];
    logic [7:0] shadow [DEPTH];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chip8_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .blt_req(blt_req), .blt_we(blt_we), .blt_addr(blt_addr), .blt_wdata(blt_wdata),
        .blt_gnt(blt_gnt), .blt_rvalid(blt_rvalid),
        .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous-read RAM, read-before-write.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #4;
    endtask

    task automatic idle;
        clear_req = 0;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        blt_req = 0; blt_we = 0; blt_addr = '0; blt_wdata = '0;
    endtask

`ifdef MEM_CLEAR_EN
    // Observes a full clear from its first cycle; returns the number of bad cycles.
    task automatic clear_sweep(output int errs);
        errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            settle;
            if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== 8'h00 ||
                busy !== 1'b1 || {ld_gnt, cpu_gnt, blt_gnt} !== 3'b000) begin
                if (errs == 0)
                    $display("  sweep cycle %0d: we=%b addr=%h data=%h busy=%b gnt=%b",
                             i, mem_we, mem_addr, mem_wdata, busy, {ld_gnt, cpu_gnt, blt_gnt});
                errs++;
            end
            step;
        end
        for (int i = 0; i < DEPTH; i++) shadow[i] = 8'h00;
    endtask
`endif

    task automatic test_reset;
        reset = 1;
        ld_req = 1; ld_we = 1; cpu_req = 1; blt_req = 1;
        step; step; settle;
        total++;
        if ({ld_gnt, cpu_gnt, blt_gnt} !== 3'b000) begin
            bad++; $display("FAIL reset_gnt got=%b want=000", {ld_gnt, cpu_gnt, blt_gnt});
        end
        total++;
        if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", mem_we); end
        total++;
        if (busy !== RST_BUSY) begin bad++; $display("FAIL reset_busy got=%b want=%b", busy, RST_BUSY); end
        total++;
        if ({cpu_rvalid, blt_rvalid} !== 2'b00) begin
            bad++; $display("FAIL reset_rvalid got=%b want=00", {cpu_rvalid, blt_rvalid});
        end
        idle;
    endtask

    task automatic test_release;
        int errs;
        step;
        reset = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h000;
`ifdef MEM_CLEAR_EN
        clear_sweep(errs);
        total++;
        if (errs != 0) begin bad++; $display("FAIL reset_clear bad_cycles=%0d want=0", errs); end
`endif
        settle;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL release_busy got=%b want=0", busy); end
        total++;
        if ({ld_gnt, cpu_gnt, blt_gnt} !== 3'b010) begin
            bad++; $display("FAIL release_cpu_gnt got=%b want=010", {ld_gnt, cpu_gnt, blt_gnt});
        end
        step;
        cpu_req = 0; blt_req = 1; blt_we = 0; blt_addr = 12'h001;
        settle;
        total++;
        if (blt_gnt !== 1'b1) begin bad++; $display("FAIL release_blt_gnt got=%b want=1", blt_gnt); end
        total++;
        if (cpu_rvalid !== 1'b1 || rdata !== shadow[0]) begin
            bad++; $display("FAIL release_cpu_read got=%b/%h want=1/%h", cpu_rvalid, rdata, shadow[0]);
        end
        step; idle; settle;
        total++;
        if (blt_rvalid !== 1'b1 || rdata !== shadow[1]) begin
            bad++; $display("FAIL release_blt_read got=%b/%h want=1/%h", blt_rvalid, rdata, shadow[1]);
        end
    endtask

    task automatic test_priority;
        for (int k = 0; k < 3; k++) begin
            step;
            ld_req = 1; ld_we = 1; ld_addr = AW'(12'h010 + k); ld_wdata = DW'(8'hC0 + k);
            cpu_req = 1; cpu_we = 1; cpu_addr = 12'h020; cpu_wdata = 8'h11;
            blt_req = 1; blt_we = 1; blt_addr = 12'h030; blt_wdata = 8'h22;
            settle;
            total++;
            if ({ld_gnt, cpu_gnt, blt_gnt} !== 3'b100) begin
                bad++; $display("FAIL prio_gnt cyc=%0d got=%b want=100", k, {ld_gnt, cpu_gnt, blt_gnt});
            end
            total++;
            if (mem_we !== 1'b1 || mem_addr !== ld_addr || mem_wdata !== ld_wdata) begin
                bad++; $display("FAIL prio_port got=%b/%h/%h want=1/%h/%h",
                                mem_we, mem_addr, mem_wdata, ld_addr, ld_wdata);
            end
            shadow[12'h010 + k] = 8'hC0 + 8'(k);
        end
        step; idle;
    endtask

    task automatic test_round_robin;
        for (int k = 0; k < 6; k++) begin
            logic [2:0] want;
            step;
            cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
            blt_req = 1; blt_we = 0; blt_addr = 12'h011;
            settle;
            want = (k % 2 == 0) ? 3'b010 : 3'b001;
            total++;
            if ({ld_gnt, cpu_gnt, blt_gnt} !== want) begin
                bad++; $display("FAIL rr_gnt cyc=%0d got=%b want=%b", k, {ld_gnt, cpu_gnt, blt_gnt}, want);
            end
            if (k > 0) begin
                total++;
                if (k % 2 == 1) begin
                    if (cpu_rvalid !== 1'b1 || rdata !== shadow[12'h010]) begin
                        bad++; $display("FAIL rr_cpu_read cyc=%0d got=%b/%h want=1/%h",
                                        k, cpu_rvalid, rdata, shadow[12'h010]);
                    end
                end else begin
                    if (blt_rvalid !== 1'b1 || rdata !== shadow[12'h011]) begin
                        bad++; $display("FAIL rr_blt_read cyc=%0d got=%b/%h want=1/%h",
                                        k, blt_rvalid, rdata, shadow[12'h011]);
                    end
                end
            end
        end
        step; idle; settle;
        total++;
        if (blt_rvalid !== 1'b1 || rdata !== shadow[12'h011]) begin
            bad++; $display("FAIL rr_last_read got=%b/%h want=1/%h", blt_rvalid, rdata, shadow[12'h011]);
        end
    endtask

    task automatic test_load_read;
        step;
        ld_req = 1; ld_we = 1; ld_addr = 12'h200; ld_wdata = 8'hA2;
        settle;
        total++;
        if (ld_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h200 || mem_wdata !== 8'hA2) begin
            bad++; $display("FAIL load_write got=%b/%b/%h/%h want=1/1/200/a2", ld_gnt, mem_we, mem_addr, mem_wdata);
        end
        shadow[12'h200] = 8'hA2;
        step;
        ld_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h200;
        settle;
        total++;
        if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h200) begin
            bad++; $display("FAIL cpu_read_gnt got=%b/%b/%h want=1/0/200", cpu_gnt, mem_we, mem_addr);
        end
        step; idle; settle;
        total++;
        if (cpu_rvalid !== 1'b1 || rdata !== 8'hA2) begin
            bad++; $display("FAIL cpu_read_data got=%b/%h want=1/a2", cpu_rvalid, rdata);
        end
        step;
        ld_req = 1; ld_we = 0; ld_addr = 12'h200; ld_wdata = 8'hFF;
        settle;
        total++;
        if (ld_gnt !== 1'b1 || mem_we !== 1'b0) begin
            bad++; $display("FAIL load_read got=%b/%b want=1/0", ld_gnt, mem_we);
        end
        step; idle; settle;
        total++;
        if ({cpu_rvalid, blt_rvalid} !== 2'b00) begin
            bad++; $display("FAIL load_read_rvalid got=%b want=00", {cpu_rvalid, blt_rvalid});
        end
    endtask

    task automatic test_clear_req;
        int errs;
        step;
        blt_req = 1; blt_we = 1; blt_addr = 12'h300; blt_wdata = 8'h55; clear_req = 1;
        settle;
        total++;
        if (blt_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h300 || mem_wdata !== 8'h55) begin
            bad++; $display("FAIL clr_blt_write got=%b/%b/%h/%h want=1/1/300/55", blt_gnt, mem_we, mem_addr, mem_wdata);
        end
        shadow[12'h300] = 8'h55;
        step; idle;
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h300;
`ifdef MEM_CLEAR_EN
        clear_sweep(errs);
        total++;
        if (errs != 0) begin bad++; $display("FAIL clr_sweep bad_cycles=%0d want=0", errs); end
`endif
        settle;
        total++;
        if (busy !== 1'b0 || cpu_gnt !== 1'b1) begin
            bad++; $display("FAIL clr_after got=%b/%b want=0/1", busy, cpu_gnt);
        end
        step; idle; settle;
        total++;
        if (cpu_rvalid !== 1'b1 || rdata !== shadow[12'h300]) begin
            bad++; $display("FAIL clr_readback got=%b/%h want=1/%h", cpu_rvalid, rdata, shadow[12'h300]);
        end
    endtask

    task automatic test_reset_midway;
        int errs;
`ifdef MEM_CLEAR_EN
        step; clear_req = 1;
        step; clear_req = 0;
        for (int i = 0; i < 1000; i++) step;
        settle;
        total++;
        if (mem_addr !== 12'd1000 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_clear_addr got=%h/%b want=3e8/1", mem_addr, busy);
        end
`endif
        step;
        reset = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h200;
        settle;
        total++;
        if (cpu_gnt !== 1'b0 || mem_we !== 1'b0 || busy !== RST_BUSY) begin
            bad++; $display("FAIL mid_reset got=%b/%b/%b want=0/0/%b", cpu_gnt, mem_we, busy, RST_BUSY);
        end
        step; settle;
        total++;
        if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL mid_reset_rvalid got=%b want=0", cpu_rvalid); end
        step;
        reset = 0;
`ifdef MEM_CLEAR_EN
        clear_sweep(errs);
        total++;
        if (errs != 0) begin bad++; $display("FAIL mid_restart bad_cycles=%0d want=0", errs); end
`endif
        settle;
        total++;
        if (busy !== 1'b0 || cpu_gnt !== 1'b1) begin
            bad++; $display("FAIL mid_after got=%b/%b want=0/1", busy, cpu_gnt);
        end
        // Read granted, then reset on the cycle its data appears: rvalid must drop.
        step; idle; reset = 1;
        step; reset = 0; settle;
        total++;
        if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL mid_read_drop got=%b want=0", cpu_rvalid); end
`ifdef MEM_CLEAR_EN
        clear_sweep(errs);
        total++;
        if (errs != 0) begin bad++; $display("FAIL mid_read_clear bad_cycles=%0d want=0", errs); end
`endif
    endtask

    task automatic test_random;
        logic       last_was_blt;
        logic       pend_cpu, pend_blt;
        logic [7:0] pend_data;
        int         hold_addr;
        // Known arbitration history: blitter served most recently.
        step; idle; blt_req = 1; blt_we = 0; blt_addr = 12'h000;
        settle;
        total++;
        if (blt_gnt !== 1'b1) begin bad++; $display("FAIL rand_prime got=%b want=1", blt_gnt); end
        step; idle;
        last_was_blt = 1; pend_cpu = 0; pend_blt = 0; pend_data = 0; hold_addr = -1;
        for (int c = 0; c < 400; c++) begin
            int         win;
            logic [2:0] want;
            logic       we_w;
            logic [AW-1:0] addr_w;
            logic [DW-1:0] data_w;
            if (c > 0) step;
            if (c == 0) begin
                settle;
                total++;
                if (blt_rvalid !== 1'b1 || rdata !== shadow[0]) begin
                    bad++; $display("FAIL rand_prime_read got=%b/%h want=1/%h", blt_rvalid, rdata, shadow[0]);
                end
                step;
            end
            ld_req  = ($urandom_range(0, 3) == 0);
            ld_we   = 1'($urandom_range(0, 1));
            ld_addr = AW'($urandom_range(0, 31));
            ld_wdata = DW'($urandom);
            cpu_req = 1'($urandom_range(0, 1));
            cpu_we  = 1'($urandom_range(0, 1));
            cpu_addr = AW'($urandom_range(0, 31));
            cpu_wdata = DW'($urandom);
            blt_req = 1'($urandom_range(0, 1));
            blt_we  = 1'($urandom_range(0, 1));
            blt_addr = AW'($urandom_range(0, 31));
            blt_wdata = DW'($urandom);
            settle;
            if (ld_req) win = 1;
            else if (cpu_req && blt_req) win = last_was_blt ? 2 : 3;
            else if (cpu_req) win = 2;
            else if (blt_req) win = 3;
            else win = 0;
            want = (win == 1) ? 3'b100 : (win == 2) ? 3'b010 : (win == 3) ? 3'b001 : 3'b000;
            total++;
            if ({ld_gnt, cpu_gnt, blt_gnt} !== want) begin
                bad++; $display("FAIL rand_gnt cyc=%0d got=%b want=%b", c, {ld_gnt, cpu_gnt, blt_gnt}, want);
            end
            total++;
            if (cpu_rvalid !== pend_cpu || blt_rvalid !== pend_blt) begin
                bad++; $display("FAIL rand_rvalid cyc=%0d got=%b%b want=%b%b", c, cpu_rvalid, blt_rvalid, pend_cpu, pend_blt);
            end
            if (pend_cpu || pend_blt) begin
                total++;
                if (rdata !== pend_data) begin
                    bad++; $display("FAIL rand_rdata cyc=%0d got=%h want=%h", c, rdata, pend_data);
                end
            end
            we_w = 0; addr_w = '0; data_w = '0;
            case (win)
                1: begin we_w = ld_we;  addr_w = ld_addr;  data_w = ld_wdata;  end
                2: begin we_w = cpu_we; addr_w = cpu_addr; data_w = cpu_wdata; end
                3: begin we_w = blt_we; addr_w = blt_addr; data_w = blt_wdata; end
                default: ;
            endcase
            if (win != 0) begin
                total++;
                if (mem_we !== we_w || mem_addr !== addr_w || (we_w && mem_wdata !== data_w)) begin
                    bad++; $display("FAIL rand_port cyc=%0d got=%b/%h/%h want=%b/%h/%h",
                                    c, mem_we, mem_addr, mem_wdata, we_w, addr_w, data_w);
                end
                hold_addr = int'(addr_w);
            end else begin
                total++;
                if (mem_we !== 1'b0 || (hold_addr >= 0 && mem_addr !== AW'(hold_addr))) begin
                    bad++; $display("FAIL rand_idle cyc=%0d got=%b/%h want=0/%h", c, mem_we, mem_addr, hold_addr);
                end
            end
            pend_cpu  = (win == 2) && !we_w;
            pend_blt  = (win == 3) && !we_w;
            pend_data = shadow[addr_w];
            if (win != 0 && we_w) shadow[addr_w] = data_w;
            if (win == 2) last_was_blt = 0;
            if (win == 3) last_was_blt = 1;
        end
        step; idle;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = RAM_INIT;
            shadow[i] = 8'h00;
        end
        idle;
        reset = 1;
        test_reset;
        test_release;
        test_priority;
        test_round_robin;
        test_load_read;
        test_clear_req;
        test_reset_midway;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
